// File: rtl/sync_updown_counter_pkg.sv
// Shared definitions for the modulo-N up/down counter: direction encoding
// and the saturating parallel-load helper.
package sync_updown_counter_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Wide enough for WIDTH=16 with MODULUS=2^16.
   localparam int SAT_W = 17;

   // A load value outside the count range clamps to the top of the range.
   function automatic logic [SAT_W-1:0] saturate_load(
      input logic [SAT_W-1:0] value,
      input logic [SAT_W-1:0] modulus
   );
      return (value < modulus) ? value : (modulus - SAT_W'(1));
   endfunction

endpackage

// File: rtl/sync_updown_counter_toggle_cell.sv
// Single toggle-type storage cell with asynchronous active-low clear;
// inverts its state on a rising clock edge whenever tin is high.
module toggle_cell (
   input  logic clkin,
   input  logic rstnin,
   input  logic tin,
   output logic qout,
   output logic qnout
);

   logic r_q;

   always_ff @(posedge clkin or negedge rstnin) begin
      if (!rstnin) begin
         r_q <= 1'b0;
      end else if (tin) begin
         r_q <= ~r_q;
      end
   end

   assign qout  = r_q;
   assign qnout = ~r_q;

endmodule

// File: rtl/sync_updown_counter.sv
// Modulo-MODULUS up/down counter built from toggle cells: next-state logic
// picks a target value and toggles exactly the bits that differ from it.
module sync_updown_counter
   import sync_updown_counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clkin,
   input  logic             rstnin,
   input  logic             enin,
   input  logic             upin,
   input  logic             loadin,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] qout,
   output logic [WIDTH-1:0] qnout,
   output logic             tcout,
   output logic             wrapout
);

   localparam logic [WIDTH:0] LP_MOD = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0] LP_MAX = (WIDTH+1)'(MODULUS - 1);

   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_qn;
   logic [WIDTH-1:0] w_n;
   logic [WIDTH-1:0] w_t;
   logic [WIDTH:0]   w_inc;
   logic [WIDTH:0]   w_dec;
   logic             w_at_max;
   logic             w_at_zero;
   logic             w_wrap_next;
   logic             r_wrap;

   // One extra bit keeps q+1 exact when MODULUS equals 2^WIDTH, and the
   // borrow out of q-1 flags q==0 directly.
   assign w_inc     = {1'b0, w_q} + (WIDTH+1)'(1);
   assign w_dec     = {1'b0, w_q} - (WIDTH+1)'(1);
   assign w_at_max  = (w_inc == LP_MOD);
   assign w_at_zero = w_dec[WIDTH];

   always_comb begin
      w_n         = w_q;
      w_wrap_next = 1'b0;
      if (loadin) begin
         w_n = WIDTH'(saturate_load(SAT_W'(din), SAT_W'(MODULUS)));
      end else if (enin) begin
         if (upin == DIR_UP) begin
            w_n         = w_at_max ? '0 : w_inc[WIDTH-1:0];
            w_wrap_next = w_at_max;
         end else begin
            w_n         = w_at_zero ? LP_MAX[WIDTH-1:0] : w_dec[WIDTH-1:0];
            w_wrap_next = w_at_zero;
         end
      end
   end

   assign w_t = w_q ^ w_n;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
         toggle_cell u_cell (
            .clkin  (clkin),
            .rstnin (rstnin),
            .tin    (w_t[gi]),
            .qout   (w_q[gi]),
            .qnout  (w_qn[gi])
         );
      end
   endgenerate

   always_ff @(posedge clkin or negedge rstnin) begin
      if (!rstnin) begin
         r_wrap <= 1'b0;
      end else begin
         r_wrap <= w_wrap_next;
      end
   end

   assign qout    = w_q;
   assign qnout   = w_qn;
   assign wrapout = r_wrap;
   assign tcout   = enin & ~loadin & ((upin & w_at_max) | (~upin & w_at_zero));

endmodule

// File: tb/tb_sync_updown_counter.sv
// Scoreboard bench for sync_updown_counter: directed and random stimulus
// against an arithmetic reference model, plus a two-stage cascade.
module tb_sync_updown_counter;

   localparam int W = 4;
   localparam int M = 10;

   logic         clk = 1'b0;
   logic         rstn;
   logic         en;
   logic         up;
   logic         load;
   logic [W-1:0] din;
   logic [W-1:0] q;
   logic [W-1:0] qn;
   logic         tc;
   logic         wrap;

   logic         c_rstn;
   logic         c_en;
   logic [W-1:0] lo_q, lo_qn, hi_q, hi_qn;
   logic         lo_tc, lo_wrap, hi_tc, hi_wrap;

   always #5 clk = ~clk;

   sync_updown_counter #(.WIDTH(W), .MODULUS(M)) u_dut (
      .clkin   (clk),
      .rstnin  (rstn),
      .enin    (en),
      .upin    (up),
      .loadin  (load),
      .din     (din),
      .qout    (q),
      .qnout   (qn),
      .tcout   (tc),
      .wrapout (wrap)
   );

   sync_updown_counter #(.WIDTH(W), .MODULUS(M)) u_lo (
      .clkin   (clk),
      .rstnin  (c_rstn),
      .enin    (c_en),
      .upin    (1'b1),
      .loadin  (1'b0),
      .din     (4'd0),
      .qout    (lo_q),
      .qnout   (lo_qn),
      .tcout   (lo_tc),
      .wrapout (lo_wrap)
   );

   sync_updown_counter #(.WIDTH(W), .MODULUS(M)) u_hi (
      .clkin   (clk),
      .rstnin  (c_rstn),
      .enin    (lo_tc),
      .upin    (1'b1),
      .loadin  (1'b0),
      .din     (4'd0),
      .qout    (hi_q),
      .qnout   (hi_qn),
      .tcout   (hi_tc),
      .wrapout (hi_wrap)
   );

   typedef struct {
      int q;
      int wrap;
      int tc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   m_q      = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Apply controls now and record what the next rising edge must produce.
   task automatic drive_now(input int l, input int e, input int u, input int d);
      exp_t it;
      load = 1'(l);
      en   = 1'(e);
      up   = 1'(u);
      din  = W'(d);
      it.tc = (e != 0 && l == 0 && ((u != 0) ? (m_q == M - 1) : (m_q == 0))) ? 1 : 0;
      it.wrap = 0;
      if (l != 0) begin
         m_q = (d < M) ? d : M - 1;
      end else if (e != 0) begin
         if (u != 0) begin
            it.wrap = (m_q == M - 1) ? 1 : 0;
            m_q     = (m_q + 1) % M;
         end else begin
            it.wrap = (m_q == 0) ? 1 : 0;
            m_q     = (m_q + M - 1) % M;
         end
      end
      it.q = m_q;
      sb.push_back(it);
      $display("step load=%0d en=%0d up=%0d din=%0d -> exp q=%0d wrap=%0d tc=%0d",
               l, e, u, d, it.q, it.wrap, it.tc);
   endtask

   task automatic step(input int l, input int e, input int u, input int d);
      @(negedge clk);
      drive_now(l, e, u, d);
   endtask

   // Reset dropped between edges must clear at once and hold through an edge.
   task automatic async_reset_check();
      @(negedge clk);
      #2;
      rstn = 1'b0;
      #1;
      check("rst_qout", int'(q), 0);
      check("rst_qnout", int'(qn), (1 << W) - 1);
      check("rst_wrapout", int'(wrap), 0);
      m_q  = 0;
      en   = 1'b1;
      up   = 1'b1;
      load = 1'b0;
      @(posedge clk);
      #1;
      check("rst_hold_qout", int'(q), 0);
      check("rst_hold_wrapout", int'(wrap), 0);
      @(negedge clk);
      rstn = 1'b1;
      drive_now(0, 0, 1, 0);
      $display("async reset applied and released");
   endtask

   // Monitor: snapshot tcout mid-cycle, compare registered outputs after the edge.
   initial begin
      int   tc_snap;
      exp_t it;
      forever begin
         @(negedge clk);
         #2;
         tc_snap = int'(tc);
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            it = sb.pop_front();
            check("tcout", tc_snap, it.tc);
            check("qout", int'(q), it.q);
            check("qnout", int'(qn), (~it.q) & ((1 << W) - 1));
            check("wrapout", int'(wrap), it.wrap);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int hi_wraps;
      rstn   = 1'b0;
      en     = 1'b0;
      up     = 1'b1;
      load   = 1'b0;
      din    = '0;
      c_rstn = 1'b0;
      c_en   = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("init_qout", int'(q), 0);
      check("init_qnout", int'(qn), (1 << W) - 1);
      check("init_wrapout", int'(wrap), 0);
      check("init_tcout", int'(tc), 0);

      // Up count through a wrap.
      @(negedge clk);
      rstn = 1'b1;
      drive_now(0, 1, 1, 0);
      repeat (11) step(0, 1, 1, 0);

      // Down count through a wrap.
      step(1, 0, 0, 2);
      repeat (4) step(0, 1, 0, 0);

      // Load beats count at terminal value; out-of-range load saturates.
      step(1, 1, 1, 9);
      step(1, 1, 1, 4);
      step(1, 0, 0, 13);

      // Hold, then direction flips.
      step(1, 0, 0, 5);
      repeat (3) step(0, 0, 1, 0);
      step(0, 1, 1, 0);
      step(0, 1, 0, 0);
      step(0, 1, 1, 0);
      step(0, 1, 0, 0);

      // Direction flip sitting on the terminal values.
      step(1, 0, 0, 9);
      step(0, 1, 1, 0);
      step(0, 1, 0, 0);
      step(0, 1, 1, 0);

      // Abandon a count mid-way.
      step(1, 0, 0, 7);
      async_reset_check();
      repeat (3) step(0, 1, 1, 0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            async_reset_check();
         end else begin
            step(($urandom_range(0, 7) == 0) ? 1 : 0,
                 ($urandom_range(0, 3) != 0) ? 1 : 0,
                 int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 15)));
         end
      end
      @(posedge clk);
      #3;
      check("scoreboard_drained", sb.size(), 0);

      // Two-stage cascade: decade counter feeding a second decade.
      @(negedge clk);
      c_rstn   = 1'b1;
      c_en     = 1'b1;
      hi_wraps = 0;
      for (int n = 0; n < 100; n++) begin
         @(posedge clk);
         #1;
         if (hi_wrap) hi_wraps++;
      end
      $display("cascade after 100 edges: hi=%0d lo=%0d hi_wraps=%0d", hi_q, lo_q, hi_wraps);
      check("cascade100_lo", int'(lo_q), 100 % M);
      check("cascade100_hi", int'(hi_q), (100 / M) % M);
      check("cascade100_hi_wraps", hi_wraps, 100 / (M * M));
      repeat (37) @(posedge clk);
      #1;
      $display("cascade after 137 edges: hi=%0d lo=%0d", hi_q, lo_q);
      check("cascade137_lo", int'(lo_q), 137 % M);
      check("cascade137_hi", int'(hi_q), (137 / M) % M);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
